// File: rtl/bus_a_operand_sel.sv
// bus_a_operand_sel: registered Bus A source multiplexer with a valid/ready
// handshake and a 2-entry (head + skid) buffer. The ALU can stall without a
// combinational ready path back into operand fetch.
//
// Optional build macro: BUS_A_ZERO_SRC_EN
//   defined   -> sel == NUM_SRC is a legal "zero operand" source
//   undefined -> sel == NUM_SRC is illegal (bus_a = 0, sel_err set)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   src_data   packed sources, source i at [i*WIDTH +: WIDTH]
//   sel        source index for the current input beat
//   in_valid   input beat valid
//   in_ready   unit can accept a beat (registered)
//   bus_a      selected operand at the head of the buffer
//   bus_a_sel  sel value that produced bus_a
//   out_valid  bus_a valid
//   out_ready  consumer accepts the head beat
//   sel_err    sticky: an illegal sel was accepted
//   beat_cnt   wrapping count of accepted output beats
module bus_a_operand_sel #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned SEL_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         bus_a,
  output logic [SEL_W-1:0]         bus_a_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sel_err,
  output logic [15:0]              beat_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   skid_data;
  logic [SEL_W-1:0]   skid_sel;

  logic               in_acc_c, out_acc_c;
  logic [WIDTH-1:0]   sel_data_c;
  logic               sel_illegal_c;
  logic               head_ld_new, head_ld_skid, skid_ld;

  assign in_acc_c  = in_valid & in_ready;
  assign out_acc_c = out_valid & out_ready;

  // Source selection; anything outside the source range yields a zero operand.
  always_comb begin
    sel_data_c = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) sel_data_c = src_data[i*WIDTH +: WIDTH];
    end
  end

`ifdef BUS_A_ZERO_SRC_EN
  assign sel_illegal_c = (32'(sel) > NUM_SRC);
`else
  assign sel_illegal_c = (32'(sel) >= NUM_SRC);
`endif

  // Occupancy next-state and buffer load controls.
  always_comb begin
    state_nxt    = state;
    head_ld_new  = 1'b0;
    head_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_acc_c) begin
          head_ld_new = 1'b1;
          state_nxt   = ONE;
        end
      end
      ONE: begin
        if (in_acc_c && out_acc_c) begin
          head_ld_new = 1'b1;
        end else if (in_acc_c) begin
          skid_ld   = 1'b1;
          state_nxt = FULL;
        end else if (out_acc_c) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_acc_c) begin
          head_ld_skid = 1'b1;
          state_nxt    = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // State, handshake flags and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      bus_a     <= '0;
      bus_a_sel <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
      sel_err   <= 1'b0;
      beat_cnt  <= 16'd0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != FULL);
      if (head_ld_new) begin
        bus_a     <= sel_data_c;
        bus_a_sel <= sel;
      end else if (head_ld_skid) begin
        bus_a     <= skid_data;
        bus_a_sel <= skid_sel;
      end
      if (skid_ld) begin
        skid_data <= sel_data_c;
        skid_sel  <= sel;
      end
      if (in_acc_c && sel_illegal_c) sel_err <= 1'b1;
      if (out_acc_c) beat_cnt <= beat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bus_a_operand_sel.sv
module tb_bus_a_operand_sel;

  logic        clk;
  logic        rst;
  logic [31:0] src_data;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bus_a;
  logic [1:0]  bus_a_sel;
  logic        out_valid;
  logic        out_ready;
  logic        sel_err;
  logic [15:0] beat_cnt;

  logic [15:0] src0, src1;
  assign src_data = {src1, src0};

  bus_a_operand_sel #(.WIDTH(16), .NUM_SRC(2), .SEL_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_data  (src_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bus_a     (bus_a),
    .bus_a_sel (bus_a_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err),
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  sel;
    logic        err;
  } beat_t;

  typedef struct {
    logic       iv;
    logic [1:0] sel;
    logic       ordy;
    logic       exp_ov;
    logic       exp_ir;
  } vec_t;

  beat_t       sb[$];
  logic [15:0] m_cnt;
  logic        m_err;
  int          tests;
  int          fails;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t model_beat(input logic [1:0] s);
    beat_t b;
    b.sel = s;
    case (s)
      2'd0:    b.data = src0;
      2'd1:    b.data = src1;
      default: b.data = 16'h0000;
    endcase
`ifdef BUS_A_ZERO_SRC_EN
    b.err = (s > 2'd2);
`else
    b.err = (s >= 2'd2);
`endif
    return b;
  endfunction

  task automatic check_outputs();
    beat_t h;
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
    chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
    chk("sel_err", 32'(sel_err), 32'(m_err));
    if (sb.size() != 0) begin
      h = sb[0];
      chk("bus_a", 32'(bus_a), 32'(h.data));
      chk("bus_a_sel", 32'(bus_a_sel), 32'(h.sel));
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, check #1 after it.
  task automatic step(input logic iv, input logic [1:0] s, input logic ordy, input logic r);
    logic  in_acc, out_acc;
    beat_t b;
    in_valid  = iv;
    sel       = s;
    out_ready = ordy;
    rst       = r;
    in_acc  = iv && (sb.size() < 2);
    out_acc = ordy && (sb.size() != 0);
    b = model_beat(s);
    @(posedge clk);
    #1;
    if (r) begin
      sb.delete();
      m_cnt = 16'd0;
      m_err = 1'b0;
    end else begin
      if (out_acc) begin
        void'(sb.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (in_acc) begin
        sb.push_back(b);
        if (b.err) m_err = 1'b1;
      end
    end
    check_outputs();
  endtask

  vec_t vecs[9];

  initial begin
    tests = 0; fails = 0;
    m_cnt = 16'd0; m_err = 1'b0;
    src0 = 16'h1234; src1 = 16'h00FF;
    in_valid = 1'b0; sel = 2'd0; out_ready = 1'b0; rst = 1'b1;

    // single beat, then stall fill / drain in order
    vecs[0] = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1};

    step(1'b0, 2'd0, 1'b0, 1'b1);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    step(1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0);
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].iv, vecs[i].sel, vecs[i].ordy, 1'b0);
      chk($sformatf("vec%0d_ov", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_ir", i), 32'(in_ready), 32'(vecs[i].exp_ir));
      if (i == 0) chk("vec0_bus_a", 32'(bus_a), 32'h00FF);
      if (i == 1) chk("vec1_beat_cnt", 32'(beat_cnt), 32'd1);
      if (i == 4) chk("stall_hold", 32'(bus_a), 32'h1234);
    end
    chk("stall_beat_cnt", 32'(beat_cnt), 32'd4);

    // streaming 20 beats after a fresh reset
    step(1'b0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 2'(i % 2), 1'b1, 1'b0);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
    end
    step(1'b0, 2'd0, 1'b1, 1'b0);
    chk("stream_beat_cnt", 32'(beat_cnt), 32'd20);

    // sources sampled only at accept
    step(1'b1, 2'd0, 1'b0, 1'b0);
    src0 = 16'hBEEF;
    step(1'b0, 2'd0, 1'b0, 1'b0);
    chk("sampled_src", 32'(bus_a), 32'h1234);
    step(1'b0, 2'd0, 1'b1, 1'b0);
    src0 = 16'h1234;

    // zero / illegal selects
    step(1'b1, 2'd2, 1'b1, 1'b0);
    chk("sel2_bus_a", 32'(bus_a), 32'h0000);
`ifdef BUS_A_ZERO_SRC_EN
    chk("sel2_err", 32'(sel_err), 32'd0);
`else
    chk("sel2_err", 32'(sel_err), 32'd1);
`endif
    step(1'b1, 2'd0, 1'b1, 1'b0);
    step(1'b1, 2'd3, 1'b1, 1'b0);
    chk("sel3_bus_a", 32'(bus_a), 32'h0000);
    chk("sel3_bus_a_sel", 32'(bus_a_sel), 32'd3);
    step(1'b0, 2'd0, 1'b1, 1'b0);
    chk("sel3_err_sticky", 32'(sel_err), 32'd1);

    // reset while FULL, then normal operation
    step(1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 2'd0, 1'b1, 1'b1);
    chk("rstfull_ov", 32'(out_valid), 32'd0);
    chk("rstfull_ir", 32'(in_ready), 32'd1);
    chk("rstfull_cnt", 32'(beat_cnt), 32'd0);
    step(1'b1, 2'd1, 1'b1, 1'b0);
    chk("post_rst_bus_a", 32'(bus_a), 32'h00FF);
    step(1'b0, 2'd0, 1'b1, 1'b0);
    chk("post_rst_cnt", 32'(beat_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
